pipe_reg_file: RTL

PIPE_REG_FILE -- requirements
Module: pipe_reg_file

---
 rtl/cpu_pkg.sv | 6 +
 rtl/reg_scoreboard.sv | 49 ++++
 rtl/pipe_reg_file.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and the hardwired-zero register index.
package cpu_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register plus a registered population count.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    set_i,
  input  logic [ADDR_W-1:0]       set_addr_i,
  input  logic                    clr0_i,
  input  logic [ADDR_W-1:0]       clr0_addr_i,
  input  logic                    clr1_i,
  input  logic [ADDR_W-1:0]       clr1_addr_i,
  output logic [(2**ADDR_W)-1:0]  busy_o,
  output logic [ADDR_W:0]         cnt_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Clears are applied first so a same-cycle issue leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr0_i) busy_d[clr0_addr_i] = 1'b0;
    if (clr1_i) busy_d[clr1_addr_i] = 1'b0;
    if (set_i)  busy_d[set_addr_i]  = 1'b1;
    if (ZERO_REG != 0) busy_d[ZADDR] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CW'(busy_d[i]);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/pipe_reg_file.sv
// Two-read / two-write register file with write-to-read bypass and a pending-write scoreboard.
module pipe_reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] wa0_i,
  input  logic [DATA_W-1:0] wd0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] wa1_i,
  input  logic [DATA_W-1:0] wd1_i,
  input  logic              iss_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  output logic [ADDR_W:0]   busy_cnt_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy;
  logic                         we0_ok, we1_ok;
  logic [1:0][ADDR_W-1:0]       rd_addr;
  logic [1:0][DATA_W-1:0]       rd_data;
  logic [1:0]                   rd_busy;

  assign we0_ok = we0_i && !(ZERO_REG != 0 && wa0_i == ZADDR);
  assign we1_ok = we1_i && !(ZERO_REG != 0 && wa1_i == ZADDR);

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (we0_ok) regs_d[wa0_i] = wd0_i;
    if (we1_ok) regs_d[wa1_i] = wd1_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rd_addr = {rt_addr_i, rs_addr_i};

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < 2; p++) begin
      if (ZERO_REG != 0 && rd_addr[p] == ZADDR) rd_data[p] = '0;
      else if (we1_i && wa1_i == rd_addr[p])    rd_data[p] = wd1_i;
      else if (we0_i && wa0_i == rd_addr[p])    rd_data[p] = wd0_i;
      else                                      rd_data[p] = regs_q[rd_addr[p]];
      // Busy is the registered bit only: a writeback this cycle shows next cycle.
      rd_busy[p] = busy[rd_addr[p]];
    end
  end

  assign rs_data_o = rd_data[0];
  assign rt_data_o = rd_data[1];
  assign rs_busy_o = rd_busy[0];
  assign rt_busy_o = rd_busy[1];

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .set_i       (iss_i),
    .set_addr_i  (iss_addr_i),
    .clr0_i      (we0_i),
    .clr0_addr_i (wa0_i),
    .clr1_i      (we1_i),
    .clr1_addr_i (wa1_i),
    .busy_o      (busy),
    .cnt_o       (busy_cnt_o)
  );
endmodule
